ddr_port_arbiter: RTL and testbench

- Shares the single block-level DDR controller port (ram_en / ram_write / ram_addr / data_to_ram / ram_rdy / block_out) between three requesters: data cache, instruction cache and a DMA master (loader/vmem copy engine).
- Sits between the cache manage unit plus DMA and ddr_ctrl.
- Performs round-robin arbitration, latches each winner's transaction and sequences the controller handshake.
- Returns read blocks and per-requester completion pulses, and flags stuck transactions.

---
 rtl/ddr_port_arbiter_if.sv | 55 +++++
 rtl/ddr_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_port_arbiter_if.sv
// Bundle of requester-side and ddr_ctrl-side signals around the DDR port arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface ddr_port_arbiter_if #(
    parameter int ADDR_W  = 30,
    parameter int BLOCK_W = 256
);
    logic               dc_req;
    logic               dc_write;
    logic [ADDR_W-1:0]  dc_addr;
    logic [BLOCK_W-1:0] dc_wdata;
    logic               dc_ack;

    logic               ic_req;
    logic [ADDR_W-1:0]  ic_addr;
    logic               ic_ack;

    logic               dma_req;
    logic               dma_write;
    logic [ADDR_W-1:0]  dma_addr;
    logic [BLOCK_W-1:0] dma_wdata;
    logic               dma_ack;

    logic [BLOCK_W-1:0] rd_block;

    logic               ram_en;
    logic               ram_write;
    logic [ADDR_W-1:0]  ram_addr;
    logic [BLOCK_W-1:0] ram_wdata;
    logic               ram_rdy;
    logic [BLOCK_W-1:0] ram_block;

    logic [2:0]         grant;
    logic               busy;
    logic               timeout_err;

    modport slave (
        input  dc_req, dc_write, dc_addr, dc_wdata,
        input  ic_req, ic_addr,
        input  dma_req, dma_write, dma_addr, dma_wdata,
        input  ram_rdy, ram_block,
        output dc_ack, ic_ack, dma_ack, rd_block,
        output ram_en, ram_write, ram_addr, ram_wdata,
        output grant, busy, timeout_err
    );

    modport master (
        output dc_req, dc_write, dc_addr, dc_wdata,
        output ic_req, ic_addr,
        output dma_req, dma_write, dma_addr, dma_wdata,
        output ram_rdy, ram_block,
        input  dc_ack, ic_ack, dma_ack, rd_block,
        input  ram_en, ram_write, ram_addr, ram_wdata,
        input  grant, busy, timeout_err
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one ddr_ctrl block port between data cache, instruction
// cache and DMA; latches the winner's transaction and sequences the ram_en/ram_rdy handshake.
module ddr_port_arbiter #(
    parameter int ADDR_W         = 30,
    parameter int BLOCK_W        = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic              clk,
    input logic              rst,
    ddr_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [2:0]  G_DC        = 3'b001;
    localparam logic [2:0]  G_IC        = 3'b010;
    localparam logic [2:0]  G_DMA       = 3'b100;

    state_e             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         grant_q, grant_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               ram_en_q, ram_en_d;
    logic               ram_write_q, ram_write_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [BLOCK_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [BLOCK_W-1:0] rd_block_q, rd_block_d;
    logic [2:0]         ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;

    logic [2:0]         req_s;
    logic [2:0]         win_s;

    // Pick the first requester after the last winner in the cyclic order dc -> ic -> dma.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [2:0] last);
        logic [2:0] pick;
        pick = 3'b000;
        case (last)
            G_DC: begin
                if (req[1])      pick = G_IC;
                else if (req[2]) pick = G_DMA;
                else if (req[0]) pick = G_DC;
                else             pick = 3'b000;
            end
            G_IC: begin
                if (req[2])      pick = G_DMA;
                else if (req[0]) pick = G_DC;
                else if (req[1]) pick = G_IC;
                else             pick = 3'b000;
            end
            default: begin
                if (req[0])      pick = G_DC;
                else if (req[1]) pick = G_IC;
                else if (req[2]) pick = G_DMA;
                else             pick = 3'b000;
            end
        endcase
        return pick;
    endfunction

    assign req_s = {bus.dma_req, bus.ic_req, bus.dc_req};
    assign win_s = rr_pick(req_s, ptr_q);

    // State and datapath registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= G_DMA;
            grant_q       <= 3'b000;
            cnt_q         <= 16'd0;
            ram_en_q      <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            rd_block_q    <= '0;
            ack_q         <= 3'b000;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            ram_en_q      <= ram_en_d;
            ram_write_q   <= ram_write_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            rd_block_q    <= rd_block_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_s != 3'b000) state_d = ST_WAIT;
                else                 state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.ram_rdy) state_d = ST_DONE;
                else             state_d = ST_WAIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; acks default low so they pulse for one cycle.
    always_comb begin
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        ram_en_d      = ram_en_q;
        ram_write_d   = ram_write_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        rd_block_d    = rd_block_q;
        ack_d         = 3'b000;
        timeout_err_d = timeout_err_q;
        busy_d        = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (win_s != 3'b000) begin
                    case (win_s)
                        G_DC: begin
                            ram_addr_d  = bus.dc_addr;
                            ram_write_d = bus.dc_write;
                            ram_wdata_d = bus.dc_wdata;
                        end
                        G_IC: begin
                            ram_addr_d  = bus.ic_addr;
                            ram_write_d = 1'b0;
                        end
                        G_DMA: begin
                            ram_addr_d  = bus.dma_addr;
                            ram_write_d = bus.dma_write;
                            ram_wdata_d = bus.dma_wdata;
                        end
                        default: begin
                            ram_addr_d  = ram_addr_q;
                        end
                    endcase
                    ram_en_d = 1'b1;
                    grant_d  = win_s;
                    ptr_d    = win_s;
                    cnt_d    = 16'd0;
                end else begin
                    ram_en_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                else                   cnt_d = cnt_q;
                if (bus.ram_rdy) begin
                    ram_en_d = 1'b0;
                    ack_d    = grant_q;
                    if (!ram_write_q) rd_block_d = bus.ram_block;
                    else              rd_block_d = rd_block_q;
                end else if (TIMEOUT_EN && (cnt_d >= TIMEOUT_LIM)) begin
                    timeout_err_d = 1'b1;
                end else begin
                    timeout_err_d = timeout_err_q;
                end
            end
            ST_DONE: begin
                grant_d = 3'b000;
            end
            default: begin
                grant_d  = 3'b000;
                ram_en_d = 1'b0;
            end
        endcase
    end

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_write   = ram_write_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.rd_block    = rd_block_q;
    assign bus.dc_ack      = ack_q[0];
    assign bus.ic_ack      = ack_q[1];
    assign bus.dma_ack     = ack_q[2];
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter with hand-computed expectations (TIMEOUT_CYCLES = 8).
module tb_ddr_port_arbiter;

    localparam int ADDR_W  = 30;
    localparam int BLOCK_W = 256;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [BLOCK_W-1:0] blk_a5;
    logic [BLOCK_W-1:0] blk_1234;
    logic [BLOCK_W-1:0] blk_ic;
    logic [BLOCK_W-1:0] blk_x;
    logic [BLOCK_W-1:0] blk_dd;

    ddr_port_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

    ddr_port_arbiter #(
        .ADDR_W(ADDR_W),
        .BLOCK_W(BLOCK_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_txn(input logic [BLOCK_W-1:0] blk);
        bus.ram_rdy   = 1'b1;
        bus.ram_block = blk;
        step();
        bus.ram_rdy   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        blk_a5   = {32{8'hA5}};
        blk_1234 = {16{16'h1234}};
        blk_ic   = {8{32'hC0DE_0001}};
        blk_x    = {8{32'hDEAD_BEEF}};
        blk_dd   = {8{32'h0D0A_0D0A}};

        rst           = 1'b0;
        bus.dc_req    = 1'b0;
        bus.dc_write  = 1'b0;
        bus.dc_addr   = '0;
        bus.dc_wdata  = '0;
        bus.ic_req    = 1'b0;
        bus.ic_addr   = '0;
        bus.dma_req   = 1'b0;
        bus.dma_write = 1'b0;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;
        bus.ram_rdy   = 1'b0;
        bus.ram_block = '0;
        step();
        step();

        // Reset state
        check("rst_ram_en", bus.ram_en, 1'b0);
        check("rst_grant", bus.grant, 3'b000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_acks", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b000);
        check("rst_tmo", bus.timeout_err, 1'b0);
        check("rst_rd_block", bus.rd_block, '0);
        rst = 1'b1;
        step();

        // Single dc read, ram_rdy five cycles after ram_en
        bus.dc_req  = 1'b1;
        bus.dc_addr = 30'h0000100;
        step();
        check("t1_ram_en_rise", bus.ram_en, 1'b1);
        check("t1_ram_addr", bus.ram_addr, 30'h0000100);
        check("t1_ram_write", bus.ram_write, 1'b0);
        check("t1_grant", bus.grant, 3'b001);
        check("t1_busy", bus.busy, 1'b1);
        repeat (5) step();
        check("t1_ram_en_c6", bus.ram_en, 1'b1);
        check("t1_no_ack_yet", bus.dc_ack, 1'b0);
        finish_txn(blk_a5);
        bus.dc_req = 1'b0;
        check("t1_ram_en_fall", bus.ram_en, 1'b0);
        check("t1_acks", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b001);
        check("t1_rd_block", bus.rd_block, blk_a5);
        check("t1_grant_done", bus.grant, 3'b001);
        step();
        check("t1_ack_drop", bus.dc_ack, 1'b0);
        check("t1_grant_idle", bus.grant, 3'b000);
        check("t1_busy_idle", bus.busy, 1'b0);

        // Round-robin from reset with all three held
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.dc_req    = 1'b1;
        bus.dc_write  = 1'b1;
        bus.dc_addr   = 30'h0000A00;
        bus.dc_wdata  = blk_1234;
        bus.ic_req    = 1'b1;
        bus.ic_addr   = 30'h0000B00;
        bus.dma_req   = 1'b1;
        bus.dma_write = 1'b1;
        bus.dma_addr  = 30'h0000C00;
        bus.dma_wdata = blk_dd;
        step();
        check("t2_grant_dc", bus.grant, 3'b001);
        check("t2_dc_write", bus.ram_write, 1'b1);
        check("t2_dc_addr", bus.ram_addr, 30'h0000A00);
        check("t2_dc_wdata", bus.ram_wdata, blk_1234);
        finish_txn(blk_x);
        check("t2_ack_dc", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b001);
        check("t2_wr_rd_block", bus.rd_block, '0);
        step();
        check("t2_gap_grant", bus.grant, 3'b000);
        step();
        check("t2_grant_ic", bus.grant, 3'b010);
        check("t2_ic_write", bus.ram_write, 1'b0);
        check("t2_ic_addr", bus.ram_addr, 30'h0000B00);
        check("t2_ic_wdata_keep", bus.ram_wdata, blk_1234);
        finish_txn(blk_ic);
        check("t2_ack_ic", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b010);
        check("t2_ic_rd_block", bus.rd_block, blk_ic);
        step();
        step();
        check("t2_grant_dma", bus.grant, 3'b100);
        check("t2_dma_write", bus.ram_write, 1'b1);
        check("t2_dma_addr", bus.ram_addr, 30'h0000C00);
        check("t2_dma_wdata", bus.ram_wdata, blk_dd);
        finish_txn(blk_x);
        check("t2_ack_dma", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b100);
        check("t2_dma_rd_keep", bus.rd_block, blk_ic);
        step();
        step();
        check("t2_grant_dc2", bus.grant, 3'b001);
        bus.dc_req  = 1'b0;
        bus.ic_req  = 1'b0;
        bus.dma_req = 1'b0;
        finish_txn(blk_x);
        check("t2_ack_dc2", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b001);
        step();

        // dc write with address/data changed during WAIT
        bus.dc_req   = 1'b1;
        bus.dc_write = 1'b1;
        bus.dc_addr  = 30'h00002A0;
        bus.dc_wdata = blk_1234;
        step();
        check("t3_wdata", bus.ram_wdata, blk_1234);
        bus.dc_addr  = 30'h00003FF;
        bus.dc_wdata = ~blk_1234;
        step();
        step();
        check("t3_wdata_held", bus.ram_wdata, blk_1234);
        check("t3_addr_held", bus.ram_addr, 30'h00002A0);
        finish_txn(blk_x);
        bus.dc_req = 1'b0;
        check("t3_ack", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b001);
        check("t3_rd_block_keep", bus.rd_block, blk_ic);
        step();

        // ram_rdy while IDLE and while DONE is ignored
        finish_txn(blk_x);
        check("t4_idle_acks", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b000);
        check("t4_idle_busy", bus.busy, 1'b0);
        check("t4_idle_rd_block", bus.rd_block, blk_ic);
        bus.ic_req  = 1'b1;
        bus.ic_addr = 30'h0000E00;
        step();
        finish_txn(blk_a5);
        bus.ic_req = 1'b0;
        check("t4_ic_ack", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b010);
        finish_txn(blk_x);
        check("t4_done_acks", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b000);
        check("t4_done_rd_block", bus.rd_block, blk_a5);
        check("t4_done_busy", bus.busy, 1'b0);
        check("t4_done_ram_en", bus.ram_en, 1'b0);
        check("t4_tmo_clear", bus.timeout_err, 1'b0);

        // Timeout after 8 WAIT cycles, late completion still acked
        bus.dma_req   = 1'b1;
        bus.dma_write = 1'b0;
        bus.dma_addr  = 30'h0000D00;
        step();
        check("t5_grant", bus.grant, 3'b100);
        repeat (7) step();
        check("t5_tmo_c8", bus.timeout_err, 1'b0);
        step();
        check("t5_tmo_c9", bus.timeout_err, 1'b1);
        check("t5_still_en", bus.ram_en, 1'b1);
        repeat (11) step();
        finish_txn(blk_dd);
        bus.dma_req = 1'b0;
        check("t5_ack", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b100);
        check("t5_rd_block", bus.rd_block, blk_dd);
        step();
        step();
        check("t5_tmo_sticky", bus.timeout_err, 1'b1);

        // Asynchronous reset mid-WAIT of an ic transaction
        bus.ic_req  = 1'b1;
        bus.ic_addr = 30'h0000F00;
        step();
        check("t6_grant_ic", bus.grant, 3'b010);
        step();
        rst = 1'b0;
        #1;
        check("t6_ram_en", bus.ram_en, 1'b0);
        check("t6_grant", bus.grant, 3'b000);
        check("t6_busy", bus.busy, 1'b0);
        check("t6_acks", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b000);
        check("t6_tmo", bus.timeout_err, 1'b0);
        step();
        rst = 1'b1;
        bus.dc_req   = 1'b1;
        bus.dc_write = 1'b0;
        step();
        check("t6_grant_dc_first", bus.grant, 3'b001);
        finish_txn(blk_a5);
        bus.dc_req = 1'b0;
        bus.ic_req = 1'b0;
        check("t6_ack_dc", {bus.dma_ack, bus.ic_ack, bus.dc_ack}, 3'b001);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
